fp_cmp_sequencer: RTL and testbench

- Multi-cycle front end of the FPU comparison path.
- Accepts two IEEE-754 single-precision operands over a valid/ready handshake.
- Produces the exponent-difference and mantissa-subtraction words that the compare stage consumes.
- Resolves and holds one-hot ordering flags (lt/eq/gt, plus unordered) until the consumer takes them.

---
 rtl/fpu_cmp_pkg.sv | 37 +++
 rtl/fp_unpack.sv | 32 +++
 rtl/fp_cmp_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fp_cmp_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_cmp_pkg.sv
// Shared types and constants for the FPU comparison front end.
package fpu_cmp_pkg;

    // Default IEEE-754 single-precision field widths and derived widths
    localparam int DEF_EXP_W  = 8;
    localparam int DEF_MAN_W  = 23;
    localparam int DEF_OP_W   = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int DEF_EDIF_W = DEF_EXP_W + 1;
    localparam int DEF_MRES_W = DEF_MAN_W + 2;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXP     = 3'd1,
        MAN     = 3'd2,
        RESOLVE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Operand split into fields, with the hidden bit restored
    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W:0]   mant_with_hidden;
        logic                 is_zero;
        logic                 is_nan;
    } fp_operand_t;

    // Ordering flags; lt/eq/gt are one-hot unless unord is set
    typedef struct packed {
        logic unord;
        logic lt;
        logic eq;
        logic gt;
    } cmp_flags_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand splitter: sign, exponent, mantissa with hidden bit,
// zero and NaN detection. Denormals keep a hidden bit of 0.
module fp_unpack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] operand,
    output logic                 sign,
    output logic [EXP_W-1:0]     exponent,
    output logic [MAN_W:0]       mant,
    output logic                 is_zero,
    output logic                 is_nan
);

    logic [MAN_W-1:0] frac;
    logic             exp_nonzero;
    logic             exp_all_ones;

    assign sign         = operand[EXP_W+MAN_W];
    assign exponent     = operand[EXP_W+MAN_W-1:MAN_W];
    assign frac         = operand[MAN_W-1:0];
    assign exp_nonzero  = |exponent;
    assign exp_all_ones = &exponent;

    // Hidden bit is present only for normalised (nonzero exponent) values
    always_comb begin
        mant    = {exp_nonzero, frac};
        is_zero = ~exp_nonzero & ~(|frac);
        is_nan  = exp_all_ones & (|frac);
    end

endmodule

// File: rtl/fp_cmp_sequencer.sv
// Multi-cycle FP compare front end: computes exponent difference, optional
// mantissa subtraction, and resolves held lt/eq/gt flags.
// Optional build macro: FP_CMP_NAN_EN (NaN operands report unordered).
module fp_cmp_sequencer
    import fpu_cmp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W:0]       exp_diff,
    output logic [MAN_W+1:0]     mantissa_res,
    output logic                 a_lt_b,
    output logic                 a_eq_b,
    output logic                 a_gt_b,
    output logic                 unordered
);

    localparam int OP_W = 1 + EXP_W + MAN_W;

    state_t           state_reg;
    logic [OP_W-1:0]  op_reg [2];

    logic             op_sign [2];
    logic [EXP_W-1:0] op_exp  [2];
    logic [MAN_W:0]   op_mant [2];
    logic             op_zero [2];
    logic             op_nan  [2];

    logic [EXP_W:0]   exp_diff_next;
    logic [MAN_W+1:0] mant_diff_next;
    logic             signs_equal;
    cmp_flags_t       flags_next;

    // Unpack both captured operands (index 0 = A, 1 = B)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            fp_unpack #(
                .EXP_W (EXP_W),
                .MAN_W (MAN_W)
            ) u_unpack (
                .operand  (op_reg[gi]),
                .sign     (op_sign[gi]),
                .exponent (op_exp[gi]),
                .mant     (op_mant[gi]),
                .is_zero  (op_zero[gi]),
                .is_nan   (op_nan[gi])
            );
        end
    endgenerate

    assign exp_diff_next  = {1'b0, op_exp[0]} - {1'b0, op_exp[1]};
    assign mant_diff_next = {1'b0, op_mant[0]} - {1'b0, op_mant[1]};
    assign signs_equal    = (op_sign[0] == op_sign[1]);

    // Ordering decision from the registered difference words
    always_comb begin
        logic mag_lt;
        logic mag_gt;
        logic mag_eq;
        flags_next = '0;
        mag_lt     = 1'b0;
        mag_gt     = 1'b0;
        mag_eq     = 1'b0;
        // Exponents decide first; mantissa_res is only meaningful when the
        // exponents matched, which is exactly when MAN was visited.
        if (exp_diff != '0) begin
            mag_lt = exp_diff[EXP_W];
            mag_gt = ~exp_diff[EXP_W];
        end else if (mantissa_res == '0) begin
            mag_eq = 1'b1;
        end else begin
            mag_lt = mantissa_res[MAN_W+1];
            mag_gt = ~mantissa_res[MAN_W+1];
        end

        if (op_zero[0] && op_zero[1]) begin
            flags_next.eq = 1'b1;
        end else if (!signs_equal) begin
            flags_next.gt = op_sign[1];
            flags_next.lt = op_sign[0];
        end else if (op_sign[0]) begin
            // Both negative: larger magnitude means smaller value
            flags_next.lt = mag_gt;
            flags_next.gt = mag_lt;
            flags_next.eq = mag_eq;
        end else begin
            flags_next.lt = mag_lt;
            flags_next.gt = mag_gt;
            flags_next.eq = mag_eq;
        end
`ifdef FP_CMP_NAN_EN
        if (op_nan[0] || op_nan[1]) begin
            flags_next = '0;
            flags_next.unord = 1'b1;
        end
`endif
    end

`ifndef FP_CMP_NAN_EN
    // NaN detection is not consumed when unordered reporting is disabled
    logic nan_unused;
    assign nan_unused = op_nan[0] ^ op_nan[1];
`endif

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_reg[0]    <= '0;
            op_reg[1]    <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            exp_diff     <= '0;
            mantissa_res <= '0;
            a_lt_b       <= 1'b0;
            a_eq_b       <= 1'b0;
            a_gt_b       <= 1'b0;
            unordered    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg[0] <= a;
                        op_reg[1] <= b;
                        in_ready  <= 1'b0;
                        state_reg <= EXP;
                    end
                end
                EXP: begin
                    exp_diff <= exp_diff_next;
                    if ((exp_diff_next == '0) && signs_equal) begin
                        state_reg <= MAN;
                    end else begin
                        state_reg <= RESOLVE;
                    end
                end
                MAN: begin
                    mantissa_res <= mant_diff_next;
                    state_reg    <= RESOLVE;
                end
                RESOLVE: begin
                    a_lt_b    <= flags_next.lt;
                    a_eq_b    <= flags_next.eq;
                    a_gt_b    <= flags_next.gt;
                    unordered <= flags_next.unord;
                    out_valid <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_cmp_sequencer.sv
// Directed self-checking bench for fp_cmp_sequencer.
module tb_fp_cmp_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  exp_diff;
    logic [24:0] mantissa_res;
    logic        a_lt_b;
    logic        a_eq_b;
    logic        a_gt_b;
    logic        unordered;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected flags packed as {unordered, lt, eq, gt}
    localparam logic [3:0] FL_LT = 4'b0100;
    localparam logic [3:0] FL_EQ = 4'b0010;
    localparam logic [3:0] FL_GT = 4'b0001;
`ifdef FP_CMP_NAN_EN
    localparam logic [3:0] FL_NAN = 4'b1000;
`else
    localparam logic [3:0] FL_NAN = 4'b0001;
`endif

    fp_cmp_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a_in),
        .b            (b_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .exp_diff     (exp_diff),
        .mantissa_res (mantissa_res),
        .a_lt_b       (a_lt_b),
        .a_eq_b       (a_eq_b),
        .a_gt_b       (a_gt_b),
        .unordered    (unordered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {unordered, a_lt_b, a_eq_b, a_gt_b};
    endfunction

    function automatic logic [39:0] snapshot();
        return {in_ready, out_valid, exp_diff, mantissa_res, unordered, a_lt_b, a_eq_b, a_gt_b};
    endfunction

    // One full operation: accept, wait for result, check, optional hold, drain
    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                          input int lat, input logic [8:0] ed, input logic [24:0] mr,
                          input logic [3:0] fl, input bit hold);
        int cnt;
        logic [39:0] snap;
        @(negedge clk);
        check({name, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a_in      = ta;
        b_in      = tb_v;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check({name, ".latency"}, 64'(cnt), 64'(lat));
        check({name, ".exp_diff"}, 64'(exp_diff), 64'(ed));
        check({name, ".mantissa_res"}, 64'(mantissa_res), 64'(mr));
        check({name, ".flags"}, 64'(flags_now()), 64'(fl));
        if (hold) begin
            snap = snapshot();
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                a_in     = 32'h4049_0FDB;
                b_in     = 32'hC000_0000;
                @(negedge clk);
                check({name, ".hold_stable"}, 64'(snapshot()), 64'(snap));
                check({name, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, ".drain"}, 64'({out_valid, in_ready}), 64'b01);
        $display("op %-10s a=%08h b=%08h lat=%0d exp_diff=%03h mant=%07h flags=%04b",
                 name, ta, tb_v, cnt, exp_diff, mantissa_res, flags_now());
    endtask

    // Reset asserted while the operation sits in MAN
    task automatic reset_in_man();
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = 32'h3FC0_0000;
        b_in     = 32'h3F80_0000;
        @(posedge clk);          // accept -> EXP
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);          // EXP -> MAN
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_man.in_ready", 64'(in_ready), 64'd1);
        check("rst_man.out_valid", 64'(out_valid), 64'd0);
        check("rst_man.flags", 64'(flags_now()), 64'd0);
        check("rst_man.exp_diff", 64'(exp_diff), 64'd0);
        check("rst_man.mantissa_res", 64'(mantissa_res), 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_man.no_result", 64'(seen), 64'd0);
        $display("op reset_in_man: in_ready=%0b out_valid=%0b stray_results=%0d", in_ready, out_valid, seen);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.exp_diff", 64'(exp_diff), 64'd0);
        check("reset.mantissa_res", 64'(mantissa_res), 64'd0);
        check("reset.flags", 64'(flags_now()), 64'd0);

        run_op("fast",     32'h3F80_0000, 32'h4000_0000, 3, 9'h1FF, 25'h0000000, FL_LT, 1'b0);
        run_op("man",      32'h3FC0_0000, 32'h3F80_0000, 4, 9'h000, 25'h0400000, FL_GT, 1'b0);
        run_op("both_neg", 32'hBF80_0000, 32'hC000_0000, 3, 9'h1FF, 25'h0400000, FL_GT, 1'b0);
        run_op("zeros",    32'h8000_0000, 32'h0000_0000, 3, 9'h000, 25'h0400000, FL_EQ, 1'b0);
        run_op("nan",      32'h7FC0_0000, 32'h3F80_0000, 3, 9'h080, 25'h0400000, FL_NAN, 1'b0);
        run_op("equal",    32'h4049_0FDB, 32'h4049_0FDB, 4, 9'h000, 25'h0000000, FL_EQ, 1'b0);
        run_op("neg_man",  32'hBFC0_0000, 32'hBF80_0000, 4, 9'h000, 25'h0400000, FL_LT, 1'b0);
        run_op("denorm",   32'h0000_0001, 32'h0000_0002, 4, 9'h000, 25'h1FFFFFF, FL_LT, 1'b0);
        run_op("sign_diff",32'h3F80_0000, 32'hBF80_0000, 3, 9'h000, 25'h1FFFFFF, FL_GT, 1'b0);
        run_op("hold",     32'h4000_0000, 32'h3F80_0000, 3, 9'h001, 25'h1FFFFFF, FL_GT, 1'b1);

        reset_in_man();
        run_op("recover",  32'h3F80_0000, 32'h3FC0_0000, 4, 9'h000, 25'h1C00000, FL_LT, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
